// File: rtl/plane_eq.sv
// plane_eq: 4-stage pipelined plane-equation evaluator, z = c + dzdx*X + dzdy*Y over a SIZE x SIZE tile.
// Optional PLANE_EQ_RNE_EN selects round-to-nearest-even; the default build truncates toward zero.
module plane_eq #(
  parameter int SIZE = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [17:0]                       dzdx,
  input  logic [17:0]                       dzdy,
  input  logic [17:0]                       c,
  input  logic [15:0]                       x,
  input  logic [15:0]                       y,
  output logic [SIZE-1:0][SIZE-1:0][17:0]   z
);

`ifdef PLANE_EQ_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  // Round, then apply saturation and flush-to-zero on the final exponent.
  function automatic logic [17:0] pack(input logic s, input int e_in, input logic [10:0] m,
                                       input logic g, input logic st);
    logic [11:0] mr;
    int e;
    mr = {1'b0, m} + {11'd0, RNE && g && (st || m[0])};
    e  = e_in + int'(mr[11]);
    if (e > 62) return {s, 6'd62, 11'h7FF};
    else if (e < 1) return '0;
    else return {s, e[5:0], mr[10:0]};
  endfunction

  function automatic logic [17:0] canon(input logic [17:0] v);
    if (v[16:11] == 6'd0) return '0;
    else if (v[16:11] == 6'd63) return {v[17], 6'd62, 11'h7FF};
    else return v;
  endfunction

  function automatic logic [17:0] int2f(input logic [16:0] v);
    logic [16:0] n;
    int unsigned p;
    p = 0;
    for (int unsigned i = 0; i < 17; i++) if (v[i]) p = i;
    n = v << (16 - p);
    if (v == '0) return '0;
    return pack(1'b0, int'(p) + 31, n[15:5], n[4], |n[3:0]);
  endfunction

  function automatic logic [17:0] fmul(input logic [17:0] a, input logic [17:0] b);
    logic [23:0] p;
    int e;
    p = 24'({1'b1, a[10:0]}) * 24'({1'b1, b[10:0]});
    e = int'(a[16:11]) + int'(b[16:11]) - 31;
    if (a[16:11] == 6'd0 || b[16:11] == 6'd0) return '0;
    if (p[23]) return pack(a[17] ^ b[17], e + 1, p[22:12], p[11], |p[10:0]);
    return pack(a[17] ^ b[17], e, p[21:11], p[10], |p[9:0]);
  endfunction

  // Guard/round/sticky alignment: the sticky bit keeps truncation exact even for
  // subtraction when the smaller operand is shifted far past the mantissa.
  function automatic logic [17:0] fadd(input logic [17:0] a, input logic [17:0] b);
    logic [17:0] big, sml;
    logic [14:0] mb, mfull, ms, lost, n;
    logic [15:0] sum;
    int unsigned d, p;
    int e;
    if (a[16:11] == 6'd0) return b;
    if (b[16:11] == 6'd0) return a;
    if (a[16:0] >= b[16:0]) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end
    d     = {26'd0, big[16:11] - sml[16:11]};
    mb    = {1'b1, big[10:0], 3'b000};
    mfull = {1'b1, sml[10:0], 3'b000};
    lost  = '0;
    if (d >= 15) begin
      ms = 15'd1;
    end else begin
      lost = mfull << (15 - d);
      ms   = (mfull >> d) | {14'd0, |lost};
    end
    if (big[17] != sml[17]) sum = {1'b0, mb} - {1'b0, ms};
    else sum = {1'b0, mb} + {1'b0, ms};
    e = int'(big[16:11]);
    if (sum == '0) return '0;
    if (sum[15]) return pack(big[17], e + 1, sum[14:4], sum[3], |sum[2:0]);
    p = 0;
    for (int unsigned i = 0; i < 15; i++) if (sum[i]) p = i;
    n = sum[14:0] << (14 - p);
    return pack(big[17], e + int'(p) - 14, n[13:3], n[2], |n[1:0]);
  endfunction

  logic [SIZE-1:0][17:0]            xf_q, yf_q, px_q, py_q;
  logic [SIZE-1:0][SIZE-1:0][17:0]  sxy_q;
  logic [17:0]                      dzdx_q, dzdy_q, c1_q, c2_q, c3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      xf_q   <= '0;
      yf_q   <= '0;
      px_q   <= '0;
      py_q   <= '0;
      sxy_q  <= '0;
      dzdx_q <= '0;
      dzdy_q <= '0;
      c1_q   <= '0;
      c2_q   <= '0;
      c3_q   <= '0;
      z      <= '0;
    end else begin
      dzdx_q <= canon(dzdx);
      dzdy_q <= canon(dzdy);
      c1_q   <= canon(c);
      c2_q   <= c1_q;
      c3_q   <= c2_q;
      // Products depend only on column or row, so SIZE multiplies per axis suffice.
      for (int unsigned i = 0; i < SIZE; i++) begin
        xf_q[i] <= int2f(17'(x) + 17'(i));
        yf_q[i] <= int2f(17'(y) + 17'(i));
        px_q[i] <= fmul(dzdx_q, xf_q[i]);
        py_q[i] <= fmul(dzdy_q, yf_q[i]);
      end
      for (int unsigned j = 0; j < SIZE; j++) begin
        for (int unsigned i = 0; i < SIZE; i++) begin
          sxy_q[j][i] <= fadd(px_q[i], py_q[j]);
          z[j][i]     <= fadd(sxy_q[j][i], c3_q);
        end
      end
    end
  end

endmodule

// File: tb/tb_plane_eq.sv
// Directed self-checking bench for plane_eq (SIZE=2, default truncating build).
module tb_plane_eq;
  logic                    clk = 1'b0;
  logic                    rst;
  logic [17:0]             dzdx, dzdy, c;
  logic [15:0]             x, y;
  logic [1:0][1:0][17:0]   z;
  int                      total = 0;
  int                      bad = 0;

  plane_eq #(.SIZE(2)) dut (
    .clk(clk), .rst(rst), .dzdx(dzdx), .dzdy(dzdy), .c(c), .x(x), .y(y), .z(z)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, total=%0d", total);
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic setv(input logic [17:0] a, input logic [17:0] b, input logic [17:0] cc,
                      input logic [15:0] xx, input logic [15:0] yy);
    dzdx = a;
    dzdy = b;
    c    = cc;
    x    = xx;
    y    = yy;
  endtask

  task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  initial begin
    // Single-edge reset pulse, then the first tile after 4 edges.
    setv(18'h0F800, 18'h0F000, 18'h00000, 16'd1, 16'd0);
    rst = 1'b1;
    tick(1);
    chk("rst_z00", z[0][0], 18'h00000);
    chk("rst_z01", z[0][1], 18'h00000);
    chk("rst_z10", z[1][0], 18'h00000);
    chk("rst_z11", z[1][1], 18'h00000);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      chk("lat_zero", z[0][0], 18'h00000);
    end
    tick(1);
    chk("t1_z00", z[0][0], 18'h0F800);
    chk("t1_z01", z[0][1], 18'h10000);
    chk("t1_z10", z[1][0], 18'h0FC00);
    chk("t1_z11", z[1][1], 18'h10200);

    // Three-edge reset with changing inputs.
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      setv(18'h0F800 + 18'(k), 18'h10000, 18'h10000, 16'(k + 7), 16'd3);
      tick(1);
      chk("rst3_z00", z[0][0], 18'h00000);
      chk("rst3_z11", z[1][1], 18'h00000);
    end
    setv(18'h0F800, 18'h0F000, 18'h00000, 16'd3, 16'd2);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      chk("rel_zero", z[0][0], 18'h00000);
    end
    tick(1);
    chk("rel_z00", z[0][0], 18'h10800);
    chk("rel_z11", z[1][1], 18'h10B00);

    // Back-to-back tiles, one per clock.
    setv(18'h0F800, 18'h00000, 18'h00000, 16'd0, 16'd0);
    tick(1);
    x = 16'd1;
    tick(1);
    x = 16'd2;
    tick(1);
    x = 16'd3;
    tick(1);
    chk("b2b_0", z[0][0], 18'h00000);
    chk("b2b_0_z01", z[0][1], 18'h0F800);
    tick(1);
    chk("b2b_1", z[0][0], 18'h0F800);
    tick(1);
    chk("b2b_2", z[0][0], 18'h10000);
    tick(1);
    chk("b2b_3", z[0][0], 18'h10400);

    // Exact cancellation and negative result.
    setv(18'h2F800, 18'h00000, 18'h10000, 16'd2, 16'd0);
    tick(4);
    chk("cancel_z00", z[0][0], 18'h00000);
    chk("neg_z01", z[0][1], 18'h2F800);

    // Overflow saturation, including X = 0x10000 without wrap.
    setv(18'h1E800, 18'h00000, 18'h00000, 16'hFFFF, 16'd0);
    tick(4);
    chk("sat_z00", z[0][0], 18'h1F7FF);
    chk("sat_z01", z[0][1], 18'h1F7FF);

    // Exponent-0 input is zero; 2^-30 is the smallest representable.
    setv(18'h003FF, 18'h00800, 18'h00000, 16'd5, 16'd0);
    tick(4);
    chk("zero_z00", z[0][0], 18'h00000);
    chk("min_z10", z[1][0], 18'h00800);

    // Subtraction result below 2^-30 flushes to +0.
    setv(18'h00FFF, 18'h00000, 18'h20800, 16'd1, 16'd0);
    tick(4);
    chk("uflow_z00", z[0][0], 18'h00000);
    chk("uflow_z01", z[0][1], 18'h013FF);

    // Int-to-float truncation of 65535 and 65536.
    setv(18'h0F800, 18'h00000, 18'h00000, 16'hFFFF, 16'd0);
    tick(4);
    chk("i2f_z00", z[0][0], 18'h177FF);
    chk("i2f_z01", z[0][1], 18'h17800);

    // 1 - 2^-20 and 2 - 2^-20 truncate toward zero.
    setv(18'h0F800, 18'h00000, 18'h25800, 16'd1, 16'd0);
    tick(4);
    chk("trunc_z00", z[0][0], 18'h0F7FF);
    chk("trunc_z01", z[0][1], 18'h0FFFF);

    // Exponent-63 inputs act as max finite of their sign.
    setv(18'h1FFFF, 18'h00000, 18'h00000, 16'd1, 16'd0);
    tick(4);
    chk("e63_pos", z[0][0], 18'h1F7FF);
    setv(18'h3FFFF, 18'h00000, 18'h00000, 16'd1, 16'd0);
    tick(4);
    chk("e63_neg", z[0][0], 18'h3F7FF);

    // Mid-stream reset discards in-flight tiles.
    setv(18'h0F800, 18'h00000, 18'h00000, 16'd1, 16'd0);
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("mid_rst", z[0][0], 18'h00000);
    rst = 1'b0;
    setv(18'h00000, 18'h00000, 18'h10000, 16'd0, 16'd0);
    tick(1);
    chk("mid_disc1", z[0][0], 18'h00000);
    tick(1);
    chk("mid_disc2", z[0][0], 18'h00000);
    tick(2);
    chk("mid_new", z[0][0], 18'h10000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
